// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for a simple in-order fetch front end.
//
// Walks each instruction through fetch, issue and optional hold, then computes
// the next PC. Redirect priority is exception, then jump, then branch, then
// sequential PC+4.
//
// Optional feature: define PC_SEQ_DELAY_SLOT_EN for one architectural branch
// delay slot. A redirect then loads PC+4 and records the target as pending. The
// following update consumes the pending target.
//
// Ports:
//   CLK          in   1   clock, rising edge
//   MasterReset  in   1   asynchronous active-high reset
//   startPC      in  32   boot address, loaded while MasterReset is high
//   Stall        in   1   downstream cannot accept the next PC update
//   BranchTaken  in   1   redirect to BranchTarget
//   BranchTarget in  32   branch destination
//   Jump         in   1   redirect to the J-format target
//   JumpIndex    in  26   J-format instruction index
//   ExcReq       in   1   current instruction raised an exception
//   IReq         out  1   instruction-memory read request
//   IAddr        out 32   instruction-memory read address
//   IAck         in   1   read complete
//   IData        in  32   read data, valid with IAck
//   PC           out 32   address of the current instruction
//   Instr        out 32   latched instruction word
//   InstrValid   out  1   one-cycle pulse when Instr/PC are valid
//   EPC          out 32   PC of the last excepting instruction
module pc_sequencer #(
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic        CLK,
    input  logic        MasterReset,
    input  logic [31:0] startPC,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [25:0] JumpIndex,
    input  logic        ExcReq,
    output logic        IReq,
    output logic [31:0] IAddr,
    input  logic        IAck,
    input  logic [31:0] IData,
    output logic [31:0] PC,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] EPC
);

    typedef enum logic [1:0] {
        StRstWait = 2'd0,
        StFetch   = 2'd1,
        StIssue   = 2'd2,
        StHold    = 2'd3
    } state_e;

    localparam logic [31:0] WordMask = 32'hFFFF_FFFC;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] epc_q, epc_d;

    logic [31:0] pc4;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] exc_target;
    logic [31:0] boot_pc;
    logic        update;

`ifdef PC_SEQ_DELAY_SLOT_EN
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
`endif

    // Address arithmetic. Every address load is word aligned.
    always_comb begin
        pc4           = pc_q + 32'd4;
        jump_target   = {pc4[31:28], JumpIndex, 2'b00};
        branch_target = BranchTarget & WordMask;
        exc_target    = EXC_VECTOR & WordMask;
        boot_pc       = startPC & WordMask;
    end

    // The PC advances only on an edge leaving ISSUE/HOLD with Stall low.
    assign update = ((state_q == StIssue) || (state_q == StHold)) && !Stall;

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRstWait: state_d = StFetch;
            StFetch:   if (IAck) state_d = StIssue;
            StIssue:   state_d = Stall ? StHold : StFetch;
            StHold:    if (!Stall) state_d = StFetch;
            default:   state_d = StRstWait;
        endcase
    end

    // Outputs. The state register resets asynchronously, so IReq drops as soon
    // as MasterReset rises.
    always_comb begin
        IReq       = (state_q == StFetch);
        IAddr      = pc_q;
        InstrValid = (state_q == StIssue);
        PC         = pc_q;
        Instr      = instr_q;
        EPC        = epc_q;
    end

    // Datapath next-state logic.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        epc_d   = epc_q;
`ifdef PC_SEQ_DELAY_SLOT_EN
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
`endif

        // IAck outside FETCH is ignored.
        if ((state_q == StFetch) && IAck) begin
            instr_d = IData;
        end

        if (update) begin
`ifdef PC_SEQ_DELAY_SLOT_EN
            if (ExcReq) begin
                // An exception kills any redirect still waiting in the delay slot.
                pc_d         = exc_target;
                epc_d        = pc_q;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                // The delay-slot instruction cannot redirect; its own redirect is dropped.
                pc_d         = pend_target_q;
                pend_valid_d = 1'b0;
            end else if (Jump) begin
                pc_d          = pc4;
                pend_valid_d  = 1'b1;
                pend_target_d = jump_target;
            end else if (BranchTaken) begin
                pc_d          = pc4;
                pend_valid_d  = 1'b1;
                pend_target_d = branch_target;
            end else begin
                pc_d = pc4;
            end
`else
            if (ExcReq) begin
                pc_d  = exc_target;
                epc_d = pc_q;
            end else if (Jump) begin
                pc_d = jump_target;
            end else if (BranchTaken) begin
                pc_d = branch_target;
            end else begin
                pc_d = pc4;
            end
`endif
        end
    end

    // State registers. Reset loads the aligned boot address.
    always_ff @(posedge CLK or posedge MasterReset) begin
        if (MasterReset) begin
            state_q <= StRstWait;
            pc_q    <= boot_pc;
            instr_q <= 32'h0;
            epc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            epc_q   <= epc_d;
        end
    end

`ifdef PC_SEQ_DELAY_SLOT_EN
    always_ff @(posedge CLK or posedge MasterReset) begin
        if (MasterReset) begin
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end
`endif

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter EXC_VECTOR, default 32'h8000_0180, exception handler address.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 MasterReset  in  1  reset, asynchronous, active-high.
REQ-004 startPC  in  32  boot address, sampled while MasterReset asserted.
REQ-005 Stall  in  1  downstream cannot accept the next PC update.
REQ-006 BranchTaken  in  1  redirect to BranchTarget; BranchTarget  in  32.
REQ-007 Jump  in  1  redirect to jump target; JumpIndex  in  26  J-format index.
REQ-008 ExcReq  in  1  exception raised by the current instruction.
REQ-009 IReq  out  1  instruction-memory read request; IAddr  out  32  request address.
REQ-010 IAck  in  1  read complete; IData  in  32  read data, valid with IAck.
REQ-011 PC  out  32  address of the current instruction; Instr  out  32  latched instruction.
REQ-012 InstrValid  out  1  one-cycle pulse, Instr/PC valid; EPC  out  32  PC of the last excepting instruction.

Function
REQ-013 FSM states: RST_WAIT, FETCH, ISSUE, HOLD; encoding is an implementation choice.
REQ-014 RST_WAIT: IReq=0; next edge goes to FETCH.
REQ-015 FETCH: IReq=1 and IAddr=PC combinationally; IAck=1 latches IData into Instr and goes to ISSUE; otherwise stays in FETCH with IAddr stable.
REQ-016 Stall is ignored in FETCH; an outstanding request always completes.
REQ-017 ISSUE: InstrValid=1 for exactly this cycle; Stall=0 updates PC per REQ-019 and goes to FETCH; Stall=1 goes to HOLD.
REQ-018 HOLD: InstrValid=0; PC and Instr held; the first cycle with Stall=0 updates PC per REQ-019 and goes to FETCH.
REQ-019 Next-PC priority, sampled only on the updating edge: ExcReq -> EXC_VECTOR, with EPC<=PC; else Jump -> {PC4[31:28],JumpIndex,2'b00}; else BranchTaken -> BranchTarget; else PC4. PC4 = PC+4.
REQ-020 PC4 is modulo 2^32: PC 32'hFFFF_FFFC yields 32'h0000_0000.
REQ-021 Bits [1:0] of every PC load (startPC, BranchTarget, EXC_VECTOR) are forced to 2'b00.
REQ-022 IAck outside FETCH is ignored; redirect and exception inputs outside an updating edge are ignored.
REQ-023 Latency: redirect in ISSUE with Stall=0 gives IAddr = target on the next cycle; with a zero-wait IAck, fetch-to-fetch is 2 cycles.

Reset
REQ-024 While MasterReset=1, immediately and independent of CLK: state=RST_WAIT, PC=startPC[31:2]<<2, Instr=0, EPC=0, InstrValid=0, IReq=0, delay-slot pending state cleared.
REQ-025 Reset asserted mid-fetch drops IReq in the same cycle; an IAck arriving during or after reset is discarded.

Configuration
REQ-026 Macro PC_SEQ_DELAY_SLOT_EN.
- Defined: a Jump or BranchTaken update loads PC4 and records the target as pending. The next updating edge loads the pending target and overrides any Jump/BranchTaken. A redirect raised by the delay-slot instruction is ignored. ExcReq on either updating edge clears the pending target, with EPC = PC of the excepting instruction.
- Undefined: redirects take effect immediately per REQ-019; no pending register exists.

Verification
REQ-027 Reset with startPC=32'h0040_0000, then release, IAck tied 1 -> IAddr sequence 0040_0000, 0040_0004, 0040_0008, one InstrValid pulse per instruction.
REQ-028 PC=32'hFFFF_FFFC, no redirect -> next IAddr 32'h0000_0000.
REQ-029 In ISSUE with PC=32'h1000_0010: assert Jump with JumpIndex=26'h0000100 and BranchTaken together -> next IAddr 32'h1000_0400 (Jump wins). Assert ExcReq as well -> next IAddr 32'h8000_0180 and EPC=32'h1000_0010.
REQ-030 Stall held 3 cycles in ISSUE with BranchTaken=1 and BranchTarget=32'h0000_2002 -> PC holds for 3 cycles, single InstrValid pulse, then IAddr 32'h0000_2000.
REQ-031 IAck delayed 4 cycles, MasterReset pulsed in cycle 2 -> IReq falls immediately, late IAck ignored, refetch from startPC.
REQ-032 With PC_SEQ_DELAY_SLOT_EN defined: branch at 32'h100 to 32'h200 -> IAddr 32'h104, then 32'h200; a branch raised at 32'h104 is ignored.
